// File: rtl/counter_spi_master_pkg.sv
// Shared types and constants for the clock-counter SPI initiator.
package counter_spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SETUP = 3'd2,
    ST_LOW   = 3'd3,
    ST_HIGH  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  // Leading command bit on the wire.
  localparam logic CMD_UPDATE = 1'b0;
  localparam logic CMD_READ   = 1'b1;

  localparam int COUNTER_BITS_DEFAULT     = 27;
  localparam int COMPARE_PPS_BITS_DEFAULT = 28;
  localparam int SCK_HALF_DEFAULT         = 8;

  function automatic int frame_bits(input int compare_bits);
    return 1 + compare_bits;
  endfunction

  localparam int FRAME_BITS = 1 + COMPARE_PPS_BITS_DEFAULT;

endpackage

// File: rtl/counter_spi_master_sck_divider.sv
// Restartable half-period tick generator: tick is high on the last clk of each
// SCK_HALF-cycle window; restart holds the window at its start.
module counter_spi_master_sck_divider #(
  parameter int SCK_HALF = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (SCK_HALF > 2) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] LOAD = CW'(SCK_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt <= LOAD;
    end else if (restart || (cnt == '0)) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = !restart && (cnt == '0);

endmodule

// File: rtl/counter_spi_master.sv
// SPI initiator for the clock-counter port: one fixed-length frame per start,
// returning flag + latched count and optionally loading a new PPS compare value.
module counter_spi_master
  import counter_spi_master_pkg::*;
#(
  parameter int COUNTER_BITS     = COUNTER_BITS_DEFAULT,
  parameter int COMPARE_PPS_BITS = COMPARE_PPS_BITS_DEFAULT,
  parameter int SCK_HALF         = SCK_HALF_DEFAULT
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        start,
  input  logic                        write_en,
  input  logic [COMPARE_PPS_BITS-1:0] wr_compare,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_flag,
  output logic [COUNTER_BITS-1:0]     rd_count,
  output logic                        spi_clk,
  output logic                        spi_sen,
  output logic                        spi_mosi,
  input  logic                        spi_miso,
  output state_t                      fsm_state
);

  // Frame must be at least as long as the slave's reply (FB >= RW).
  localparam int FB = frame_bits(COMPARE_PPS_BITS);
  localparam int RW = COUNTER_BITS + 1;
  localparam int BW = $clog2(FB + 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FB - 1);
  localparam logic [BW-1:0] SAMPLE_MIN = BW'(FB - RW);

  state_t          state, next_state;
  logic            tick;
  logic            sync_half;
  logic [BW-1:0]   bit_cnt;
  logic [FB-1:0]   tx_shift;
  logic [RW-1:0]   rx_shift;

  assign fsm_state = state;

  counter_spi_master_sck_divider #(.SCK_HALF(SCK_HALF)) u_div (
    .clk     (clk),
    .nreset  (nreset),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start) next_state = ST_SYNC;
      ST_SYNC:  if (tick && sync_half) next_state = ST_SETUP;
      ST_SETUP: if (tick) next_state = ST_LOW;
      ST_LOW:   if (tick) next_state = ST_HIGH;
      ST_HIGH:  if (tick) next_state = (bit_cnt == '0) ? ST_HOLD : ST_LOW;
      ST_HOLD:  if (tick) next_state = ST_GAP;
      ST_GAP:   if (tick) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_flag   <= 1'b0;
      rd_count  <= '0;
      spi_clk   <= 1'b0;
      spi_sen   <= 1'b1;
      spi_mosi  <= 1'b1;
      sync_half <= 1'b0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          // SYNC opens with spi_clk high while deselected: the slave's clear edge.
          busy      <= 1'b1;
          tx_shift  <= {~write_en, wr_compare};
          spi_clk   <= 1'b1;
          sync_half <= 1'b0;
        end
        ST_SYNC: if (tick) begin
          spi_clk   <= 1'b0;
          sync_half <= 1'b1;
          if (sync_half) begin
            spi_sen  <= 1'b0;
            spi_mosi <= tx_shift[FB-1];
            bit_cnt  <= LAST_BIT;
          end
        end
        ST_LOW: if (tick) begin
          if (bit_cnt >= SAMPLE_MIN) rx_shift <= {rx_shift[RW-2:0], spi_miso};
          spi_clk <= 1'b1;
        end
        ST_HIGH: if (tick) begin
          spi_clk <= 1'b0;
          if (bit_cnt != '0) begin
            bit_cnt  <= bit_cnt - 1'b1;
            tx_shift <= {tx_shift[FB-2:0], 1'b0};
            spi_mosi <= tx_shift[FB-2];
          end
        end
        ST_HOLD: if (tick) begin
          spi_sen  <= 1'b1;
          spi_mosi <= 1'b1;
        end
        ST_GAP: if (tick) begin
          done     <= 1'b1;
          busy     <= 1'b0;
          rd_flag  <= rx_shift[COUNTER_BITS];
          rd_count <= rx_shift[COUNTER_BITS-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_spi_master.sv
// Bench for counter_spi_master: two instances (SCK_HALF 8 and 2), each wired to
// a behavioural clock-counter slave; read data is checked through a scoreboard.
module tb_counter_spi_master;
  import counter_spi_master_pkg::*;

  localparam int CB = 27;
  localparam int CP = 28;
  localparam int FB = 29;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic [1:0] start = '0;
  logic write_en = 1'b0;
  logic [CP-1:0] wr_compare = '0;
  logic [1:0] busy, done, rd_flag, sclk, sen, mosi, miso;
  logic [1:0][CB-1:0] rd_count;
  logic [1:0][2:0] fsm_state;

  logic [1:0][CB-1:0] pps_count = '0;
  int pps_n [2] = '{0, 0};
  logic [1:0] fresh = '0;
  logic [CB:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_u
    localparam int SH = (g == 0) ? 8 : 2;
    logic [CB:0] out_sr = '0;
    logic [FB-1:0] in_sr = '0;
    logic [CP-1:0] compare = '0;
    int nbits = 0;
    int taken = 0;
    int rise_lo = 0;
    int rise_hi = 0;
    int mosi_viol = 0;
    time mosi_t = 0;

    counter_spi_master #(.COUNTER_BITS(CB), .COMPARE_PPS_BITS(CP), .SCK_HALF(SH)) u_dut (
      .clk        (clk),
      .nreset     (nreset),
      .start      (start[g]),
      .write_en   (write_en),
      .wr_compare (wr_compare),
      .busy       (busy[g]),
      .done       (done[g]),
      .rd_flag    (rd_flag[g]),
      .rd_count   (rd_count[g]),
      .spi_clk    (sclk[g]),
      .spi_sen    (sen[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso[g]),
      .fsm_state  (fsm_state[g])
    );

    assign miso[g] = (sen[g] === 1'b0) ? out_sr[CB] : 1'b0;

    always @(mosi[g]) mosi_t = $time;

    // Slave: transaction state clears only on a rising spi_clk while deselected.
    always @(sclk[g]) begin
      if (sclk[g] === 1'b1) begin
        if (sen[g] === 1'b1) begin
          nbits = 0;
          out_sr = (pps_n[g] != taken) ? {1'b1, pps_count[g]} : '0;
          taken = pps_n[g];
          rise_hi++;
        end else if (sen[g] === 1'b0) begin
          in_sr = {in_sr[FB-2:0], mosi[g]};
          nbits++;
          rise_lo++;
          if (($time - mosi_t) < (SH - 1) * 10) mosi_viol++;
          if (nbits == FB && in_sr[FB-1] == CMD_UPDATE) compare = in_sr[CP-1:0];
        end
      end else if (sen[g] === 1'b0) begin
        out_sr = {out_sr[CB-1:0], 1'b0};
      end
    end
  end

  function automatic int stat(input int u, input int k);
    if (u == 0) begin
      case (k)
        0: return gen_u[0].rise_lo;
        1: return gen_u[0].rise_hi;
        2: return gen_u[0].mosi_viol;
        3: return int'(gen_u[0].compare);
        default: return int'(gen_u[0].in_sr[FB-1]);
      endcase
    end
    case (k)
      0: return gen_u[1].rise_lo;
      1: return gen_u[1].rise_hi;
      2: return gen_u[1].mosi_viol;
      3: return int'(gen_u[1].compare);
      default: return int'(gen_u[1].in_sr[FB-1]);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pps(input int u, input logic [CB-1:0] c);
    pps_count[u] = c;
    pps_n[u]++;
    fresh[u] = 1'b1;
  endtask

  task automatic run_frame(input int u, input logic we, input logic [CP-1:0] cmp,
                           input bit poke_start);
    int n, sh, lo0, hi0, v0;
    logic [CB:0] got_rd, exp_rd;
    sh = (u == 0) ? 8 : 2;
    exp_q.push_back(fresh[u] ? {1'b1, pps_count[u]} : '0);
    fresh[u] = 1'b0;
    lo0 = stat(u, 0);
    hi0 = stat(u, 1);
    v0  = stat(u, 2);
    write_en = we;
    wr_compare = cmp;
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    check("busy_set", 64'(busy[u]), 64'(1));
    n = 0;
    while (done[u] !== 1'b1 && n < 4000) begin
      start[u] = poke_start && (n >= 40) && (n < 44);
      @(posedge clk); #1;
      n++;
    end
    start[u] = 1'b0;
    check("done_cycle", 64'(n), 64'(63 * sh));
    check("busy_clr", 64'(busy[u]), 64'(0));
    got_rd = {rd_flag[u], rd_count[u]};
    exp_rd = exp_q.pop_front();
    check("rd_data", 64'(got_rd), 64'(exp_rd));
    check("rise_sen_low", 64'(stat(u, 0) - lo0), 64'(FB));
    check("rise_sen_high", 64'(stat(u, 1) - hi0), 64'(1));
    check("mosi_stable", 64'(stat(u, 2) - v0), 64'(0));
    if (we) begin
      check("compare", 64'(stat(u, 3)), 64'(cmp));
      check("cmd_bit", 64'(stat(u, 4)), 64'(CMD_UPDATE));
    end else begin
      check("cmd_bit", 64'(stat(u, 4)), 64'(CMD_READ));
    end
    @(posedge clk); #1;
    check("done_pulse", 64'(done[u]), 64'(0));
  endtask

  initial begin
    int nd;
    logic [CP-1:0] rc;
    logic [CB-1:0] rcnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy[0]), 64'(0));
    check("rst_done", 64'(done[0]), 64'(0));
    check("rst_flag", 64'(rd_flag[0]), 64'(0));
    check("rst_count", 64'(rd_count[0]), 64'(0));
    check("rst_sclk", 64'(sclk[0]), 64'(0));
    check("rst_sen", 64'(sen[0]), 64'(1));
    check("rst_mosi", 64'(mosi[0]), 64'(1));
    check("rst_state", 64'(fsm_state[0]), 64'(ST_IDLE));
    check("rst_sen_b", 64'(sen[1]), 64'(1));
    nreset = 1'b1;
    @(posedge clk); #1;

    pps(0, 27'h5A5A5A5);
    run_frame(0, 1'b0, CP'($urandom), 1'b0);
    run_frame(0, 1'b1, 28'h0000010, 1'b0);

    pps(0, 27'h1234567);
    run_frame(0, 1'b0, CP'($urandom), 1'b0);
    run_frame(0, 1'b0, CP'($urandom), 1'b0);

    pps(0, 27'h7654321);
    run_frame(0, 1'b0, 28'h0F0F0F0, 1'b1);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) nd++;
    end
    check("single_done", 64'(nd), 64'(0));

    // Abort a write frame during bit 10.
    write_en = 1'b1;
    wr_compare = 28'hFFFFFFF;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (23 * 8 + 2) @(posedge clk);
    #1;
    check("abort_midframe", 64'(sen[0]), 64'(0));
    nreset = 1'b0;
    @(posedge clk); #1;
    check("abort_sen", 64'(sen[0]), 64'(1));
    check("abort_sclk", 64'(sclk[0]), 64'(0));
    check("abort_busy", 64'(busy[0]), 64'(0));
    check("abort_done", 64'(done[0]), 64'(0));
    check("abort_rd", 64'({rd_flag[0], rd_count[0]}), 64'(0));
    check("abort_state", 64'(fsm_state[0]), 64'(ST_IDLE));
    nreset = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done[0] === 1'b1) nd++;
    end
    check("abort_no_done", 64'(nd), 64'(0));
    run_frame(0, 1'b1, 28'h0ABCDE1, 1'b0);

    pps(1, 27'h2C3A5F1);
    run_frame(1, 1'b1, 28'h9C3A5F1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rc = CP'($urandom);
      rcnt = CB'($urandom);
      if ($urandom_range(0, 1) == 1) pps(1, rcnt);
      run_frame(1, 1'($urandom_range(0, 1)), rc, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_spi_master.md
# counter_spi_master

SPI initiator for the clock-counter serial port: runs one fixed-length frame that reads the latched GPS/1PPS count (with its valid flag) and can optionally load a new 1PPS divider compare value. Sits in the CPLD/FPGA host-side logic or a test harness, between a local controller (start/done handshake) and the counter's spi_clk/spi_sen/data pins. One frame per start request.

## Interface
- COUNTER_BITS, 27, width of the count field; the slave returns COUNTER_BITS+1 bits (flag + count).
- COMPARE_PPS_BITS, 28, width of the compare value written after the command bit.
- SCK_HALF, 8, spi_clk half-period in clk cycles; ≥2, and ≥4 slave clock periods in real time.
- Derived: FRAME_BITS = 1 + COMPARE_PPS_BITS (29); requires FRAME_BITS ≥ COUNTER_BITS+1.

- clk  in  1  master clock.
- nreset  in  1  reset; synchronous and active-low.
- start  in  1  frame request, sampled only in IDLE.
- write_en  in  1  captured with start: 1 = update compare, 0 = read only.
- wr_compare  in  COMPARE_PPS_BITS  captured with start; sent MSB first.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- rd_flag  out  1  new-data flag from last frame (first MISO bit).
- rd_count  out  COUNTER_BITS  count from last frame, MSB first on the wire.
- spi_clk  out  1  serial clock, idle low.
- spi_sen  out  1  slave select, active low.
- spi_mosi  out  1  to slave data in.
- spi_miso  in  1  from slave data out.

## Operation
- Reset values: busy 0, done 0, rd_flag 0, rd_count 0, spi_clk 0, spi_sen 1, spi_mosi 1; state IDLE.
- States: IDLE → SYNC → SETUP → LOW ↔ HIGH (FRAME_BITS times) → HOLD → GAP → IDLE.
- IDLE: start=1 captures write_en/wr_compare into a FRAME_BITS shift register: bit FRAME_BITS-1 = ~write_en (command: 0 = update), then wr_compare MSB..LSB. start while busy is ignored.
- SYNC: one spi_clk pulse (SCK_HALF high, SCK_HALF low) with spi_sen=1; mandatory every frame because the slave clears its transaction state only on a rising spi_clk while deselected (recovers from aborted frames).
- SETUP: spi_sen=0, spi_clk=0, spi_mosi=command bit, SCK_HALF cycles.
- LOW: last cycle samples spi_miso into a receive shifter if bit index < COUNTER_BITS+1; then spi_clk rises. HIGH: SCK_HALF cycles; on exit spi_clk falls and spi_mosi advances to next bit. Bit index 0..FRAME_BITS-1.
- Remaining read-only payload bits are don't-care to the slave; drive wr_compare anyway.
- HOLD: spi_clk=0, spi_sen=0 for SCK_HALF; then spi_sen=1, spi_mosi=1. GAP: SCK_HALF cycles deselected.
- GAP exit: rd_flag = first sampled bit, rd_count = next COUNTER_BITS bits; done=1 for one cycle; busy=0 same cycle. rd_* hold until next done.
- Reading drains the slave's flag; a second frame before the next PPS edge returns rd_flag=0.

## Timing
- start accepted at cycle 0 → busy=1 from cycle 1; done at cycle 63·SCK_HALF (SYNC 2, SETUP 1, bits 58, HOLD 1, GAP 1 half-periods); next start accepted the cycle after done.
- MISO sampled one clk before each spi_clk rise; MOSI changes only with spi_clk falling (or in SETUP), stable ≥ SCK_HALF−1 cycles before rise.
- nreset=0 mid-frame: all outputs to reset values next edge, frame discarded, no done, rd_* cleared.
- Divider and bit counter: simple down-counters, no wrap; bit counter 5 bits for defaults, width $clog2(FRAME_BITS+1).

## Structure
- Shared package: state enum, FRAME_BITS, command encodings (CMD_UPDATE=0, CMD_READ=1).
- One sub-module natural: spi_sck_divider (half-period tick generator, restartable).

## Test plan
- Read-only, slave model count=0x5A5A5A5, flag=1: rd_flag=1, rd_count=0x5A5A5A5, done at cycle 504 (SCK_HALF=8).
- Write, wr_compare=0x000_0010: slave compare = 16 after frame; command bit on wire = 0; 29 rising edges with sen low, 1 with sen high.
- Two back-to-back reads, no PPS between: second returns rd_flag=0, rd_count=0.
- start pulsed while busy: ignored; exactly one done; wire identical to single frame.
- nreset low at bit 10: spi_sen=1, spi_clk=0 next cycle, busy=0, no done; following write still loads compare correctly (SYNC recovery).
- SCK_HALF=2 with slave at same clk: frame still decodes correctly; MOSI stable at every rise.
